// File: rtl/riscv_fetch_queue.sv
// Instruction prefetch queue: issues sequential imem reads, buffers {pc,instr} pairs, and hands them to decode.
// Optional perf counters are built when the FETCH_PERF_EN macro is defined.
module riscv_fetch_queue #(
  parameter int          DEPTH      = 4,
  parameter int          IMEM_WORDS = 56,
  parameter logic [31:0] EOF_WORD   = 32'hFFFF_FFFF
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  output logic        imem_rd_en,
  output logic [31:0] imem_index,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);

  localparam int          PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW         = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_OCC  = (CW + 1)'(DEPTH);
  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          halted_q, halted_d;
  logic [31:0]   last_instr_q, last_instr_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic [CW:0] occupancy;
  logic        in_range;
  logic        issue;
  logic        push;
  logic        pop;
  logic        eof_push;
  logic [31:0] head_instr;
  logic [31:0] head_pc;

  // A pop in the same cycle does not free a slot for issue: occupancy counts the inflight response.
  assign occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign in_range   = (fetch_pc_q >> 2) < IMEM_LIMIT;
  assign issue      = !rst && !halted_q && !redirect && (occupancy < DEPTH_OCC) && in_range;
  assign push       = inflight_q && !redirect && !rst;
  assign eof_push   = push && (imem_data == EOF_WORD);
  assign pop        = id_valid && id_ready;

  assign head_instr = instr_mem_q[rd_ptr_q];
  assign head_pc    = pc_mem_q[rd_ptr_q];

  assign imem_rd_en = issue;
  assign imem_index = fetch_pc_q >> 2;
  assign id_valid   = (count_q != '0) && !redirect && !rst;
  assign id_instr   = rst ? 32'h0 : ((count_q != '0) ? head_instr : last_instr_q);
  assign id_pc      = rst ? 32'h0 : ((count_q != '0) ? head_pc : last_pc_q);
  assign halted     = halted_q && !rst;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    halted_d      = halted_q;
    last_instr_d  = last_instr_q;
    last_pc_d     = last_pc_q;
    if (redirect) begin
      // Flush everything, including a response still on its way back.
      fetch_pc_d = redirect_pc & ~32'h3;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      halted_d   = 1'b0;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
      // Anything fetched past the end marker is dropped.
      if (eof_push) begin
        inflight_d = 1'b0;
        halted_d   = 1'b1;
      end
      if (!halted_q && !in_range) begin
        halted_d = 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + PW'(1);
        last_instr_d = head_instr;
        last_pc_d    = head_pc;
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      fetch_pc_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      halted_q      <= 1'b0;
      last_instr_q  <= '0;
      last_pc_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      halted_q      <= halted_d;
      last_instr_q  <= last_instr_d;
      last_pc_q     <= last_pc_d;
    end
  end

  // Entry storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_data;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  always_comb begin
    fetch_count_d  = fetch_count_q + {31'b0, pop};
    bubble_count_d = bubble_count_q + {31'b0, (id_ready && !id_valid && !rst)};
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign fetch_count  = rst ? 32'h0 : fetch_count_q;
  assign bubble_count = rst ? 32'h0 : bubble_count_q;
`else
  assign fetch_count  = 32'h0;
  assign bubble_count = 32'h0;
`endif

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: instruction-stream model checked every cycle plus directed scenarios
// with hand-derived cycle timings.
module tb_riscv_fetch_queue;

  localparam logic [31:0] EOF = 32'hFFFF_FFFF;

  logic        CLOCK_50;
  logic        rst;
  logic        imem_rd_en;
  logic [31:0] imem_index;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        halted;
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;

  logic [31:0] mem [0:63];

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;
  logic        exp_done;
  logic [31:0] exp_fc;
  int          n_pop;

  riscv_fetch_queue dut (
    .CLOCK_50    (CLOCK_50),
    .rst         (rst),
    .imem_rd_en  (imem_rd_en),
    .imem_index  (imem_index),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .halted      (halted),
    .fetch_count (fetch_count),
    .bubble_count(bubble_count)
  );

  // Clock / reset
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Instruction memory: data one cycle after the request, junk otherwise.
  always @(posedge CLOCK_50) begin
    if (imem_rd_en) imem_data <= mem[imem_index[5:0]];
    else            imem_data <= 32'hBADC_0FFE;
  end

  function automatic logic [31:0] pv(input logic [31:0] v);
`ifdef FETCH_PERF_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: the delivered stream must be program order from the last start point,
  // each instruction matching memory, ending after EOF or the last memory word.
  always @(negedge CLOCK_50) begin
    if (rst) begin
      chk("rst_id_valid", 32'(id_valid), 32'h0);
      chk("rst_rd_en", 32'(imem_rd_en), 32'h0);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_instr", id_instr, 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_fetch_count", fetch_count, 32'h0);
      chk("rst_bubble_count", bubble_count, 32'h0);
      exp_pc   = 32'h0;
      exp_done = 1'b0;
      exp_fc   = 32'h0;
      n_pop    = 0;
    end else begin
      chk("fetch_count", fetch_count, pv(exp_fc));
      if (imem_rd_en) begin
        chk("rd_index_range", 32'(imem_index < 32'd56), 32'h1);
        chk("rd_while_halted", 32'(halted), 32'h0);
      end
      if (redirect) begin
        chk("redir_id_valid", 32'(id_valid), 32'h0);
        chk("redir_rd_en", 32'(imem_rd_en), 32'h0);
        exp_pc   = redirect_pc & ~32'h3;
        exp_done = 1'b0;
      end else if (id_valid) begin
        chk("stream_after_end", 32'(exp_done), 32'h0);
        chk("stream_pc", id_pc, exp_pc);
        chk("stream_instr", id_instr, mem[exp_pc[7:2]]);
        if (id_ready) begin
          exp_fc = exp_fc + 32'd1;
          n_pop++;
          if (mem[exp_pc[7:2]] == EOF || exp_pc[31:2] >= 30'd55) exp_done = 1'b1;
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Returns at the start of the first cycle with rst low.
  task automatic do_reset(input int eof_at, input bit prog_a);
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = (i == eof_at) ? EOF : (32'h1000_0000 + 32'(i) * 32'h11);
    end
    if (prog_a) begin
      mem[0] = 32'h00A0_0093;
      mem[1] = 32'h0010_0113;
      mem[2] = 32'h0020_81B3;
    end
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    int last_idx;
    int k;
    bit done;

    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b0;

    // Four-word program ending in EOF, decode always ready.
    id_ready = 1'b1;
    do_reset(3, 1'b1);
    @(negedge CLOCK_50);
    chk("a_c1_rd_en", 32'(imem_rd_en), 32'h1);
    chk("a_c1_index", imem_index, 32'h0);
    chk("a_c1_id_valid", 32'(id_valid), 32'h0);
    @(negedge CLOCK_50);
    chk("a_c2_index", imem_index, 32'h1);
    chk("a_c2_id_valid", 32'(id_valid), 32'h0);
    @(negedge CLOCK_50);
    chk("a_c3_id_valid", 32'(id_valid), 32'h1);
    chk("a_c3_pc", id_pc, 32'h0);
    chk("a_c3_instr", id_instr, 32'h00A0_0093);
    chk("a_c3_bubbles", bubble_count, pv(32'd2));
    @(negedge CLOCK_50);
    chk("a_c4_pc", id_pc, 32'h4);
    chk("a_c4_instr", id_instr, 32'h0010_0113);
    @(negedge CLOCK_50);
    chk("a_c5_pc", id_pc, 32'h8);
    chk("a_c5_instr", id_instr, 32'h0020_81B3);
    chk("a_c5_halted", 32'(halted), 32'h0);
    @(negedge CLOCK_50);
    chk("a_c6_pc", id_pc, 32'hC);
    chk("a_c6_instr", id_instr, EOF);
    chk("a_c6_halted", 32'(halted), 32'h1);
    chk("a_c6_rd_en", 32'(imem_rd_en), 32'h0);
    @(negedge CLOCK_50);
    chk("a_c7_id_valid", 32'(id_valid), 32'h0);
    chk("a_c7_fetch_count", fetch_count, pv(32'd4));
    repeat (3) @(negedge CLOCK_50);
    chk("a_c10_id_valid", 32'(id_valid), 32'h0);
    chk("a_c10_halted", 32'(halted), 32'h1);

    // Decode stalled for ten cycles: queue fills, issue stops, then drains in order.
    id_ready = 1'b0;
    do_reset(-1, 1'b0);
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLOCK_50);
      if (imem_rd_en) pulses++;
      if (c == 10) begin
        chk("b_full_rd_en", 32'(imem_rd_en), 32'h0);
        chk("b_full_id_valid", 32'(id_valid), 32'h1);
        chk("b_full_head_pc", id_pc, 32'h0);
      end
    end
    chk("b_issue_pulses", 32'(pulses), 32'd4);
    tick();
    id_ready = 1'b1;
    repeat (12) @(negedge CLOCK_50);
    tick();
    chk("b_drained_pops", 32'(n_pop), 32'd12);

    // Redirect with three entries queued and one response inflight.
    id_ready = 1'b0;
    do_reset(-1, 1'b0);
    repeat (4) @(negedge CLOCK_50);
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h20;
    id_ready    = 1'b1;
    @(negedge CLOCK_50);
    chk("c_redir_id_valid", 32'(id_valid), 32'h0);
    tick();
    redirect = 1'b0;
    @(negedge CLOCK_50);
    chk("c_refetch_rd_en", 32'(imem_rd_en), 32'h1);
    chk("c_refetch_index", imem_index, 32'h8);
    chk("c_no_pop_counted", fetch_count, 32'h0);
    @(negedge CLOCK_50);
    chk("c_c7_id_valid", 32'(id_valid), 32'h0);
    @(negedge CLOCK_50);
    chk("c_c8_id_valid", 32'(id_valid), 32'h1);
    chk("c_c8_pc", id_pc, 32'h20);
    repeat (5) @(negedge CLOCK_50);

    // Straight-line code running off the end of memory.
    id_ready = 1'b1;
    do_reset(-1, 1'b0);
    last_idx = -1;
    k        = 0;
    done     = 1'b0;
    while (!done && k < 150) begin
      @(negedge CLOCK_50);
      k++;
      if (imem_rd_en) last_idx = int'(imem_index);
      if (halted && !id_valid) done = 1'b1;
    end
    chk("d_halt_reached", 32'(done), 32'h1);
    tick();
    chk("d_last_index", 32'(last_idx), 32'd55);
    chk("d_halted", 32'(halted), 32'h1);
    chk("d_delivered", 32'(n_pop), 32'd56);
    chk("d_fetch_count", fetch_count, pv(32'd56));

    // One-cycle reset pulse with two entries queued.
    id_ready = 1'b1;
    do_reset(-1, 1'b0);
    repeat (6) @(negedge CLOCK_50);
    tick();
    id_ready = 1'b0;
    @(negedge CLOCK_50);
    chk("e_pre_fetch_count", fetch_count, pv(32'd4));
    tick();
    rst = 1'b1;
    @(negedge CLOCK_50);
    tick();
    rst = 1'b0;
    @(negedge CLOCK_50);
    chk("e_id_valid", 32'(id_valid), 32'h0);
    chk("e_rd_en", 32'(imem_rd_en), 32'h1);
    chk("e_index", imem_index, 32'h0);
    chk("e_fetch_count", fetch_count, 32'h0);
    chk("e_bubble_count", bubble_count, 32'h0);
    tick();
    id_ready = 1'b1;
    @(negedge CLOCK_50);
    chk("e_c10_id_valid", 32'(id_valid), 32'h0);
    @(negedge CLOCK_50);
    chk("e_c11_id_valid", 32'(id_valid), 32'h1);
    chk("e_c11_pc", id_pc, 32'h0);
    repeat (4) @(negedge CLOCK_50);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_fetch_queue.md
RISCV_FETCH_QUEUE -- requirements
Module: riscv_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of 2, 2..16).
REQ-002 SHALL have parameter IMEM_WORDS, default 56, instruction-memory size in 32-bit words.
REQ-003 SHALL have parameter EOF_WORD, default 32'hFFFF_FFFF, end-of-program marker.
REQ-004 SHALL have ports:
  CLOCK_50  in  1  sole clock, rising edge; one clock.
  rst  in  1  reset, synchronous, active-high.
  imem_rd_en  out  1  instruction-memory read request.
  imem_index  out  32  word index (fetch PC >> 2).
  imem_data  in  32  read data, valid exactly 1 cycle after imem_rd_en.
  redirect  in  1  taken branch/jump; flush and refetch.
  redirect_pc  in  32  byte address of new fetch target.
  id_ready  in  1  decode stage accepts (not stalled).
  id_valid  out  1  head entry valid for decode.
  id_instr  out  32  head instruction.
  id_pc  out  32  byte PC of head instruction.
  halted  out  1  fetch stopped (EOF fetched or index past IMEM_WORDS).
  fetch_count  out  32  instructions delivered (perf).
  bubble_count  out  32  cycles id_ready=1 with id_valid=0 (perf).

Function
REQ-005 SHALL hold fetch_pc (32b), FIFO of DEPTH {pc,instr} pairs, occupancy count (0..DEPTH), 1-bit inflight flag with captured pc.
REQ-006 SHALL assert imem_rd_en when !rst, !halted, !redirect, and count + inflight < DEPTH (pop in same cycle not credited).
REQ-007 SHALL drive imem_index = fetch_pc >> 2; on issue fetch_pc += 4 and inflight set next cycle, tagged with issued pc.
REQ-008 SHALL push {tagged pc, imem_data} at end of the cycle after issue if inflight still valid.
REQ-009 SHALL drive id_valid = (count != 0) && !redirect; id_instr/id_pc from FIFO head storage (registered, no imem_data bypass).
REQ-010 SHALL pop head when id_valid && id_ready; simultaneous push and pop leave count unchanged.
REQ-011 Latency: imem_rd_en in cycle C -> id_valid earliest in C+2; steady state one instruction per cycle with id_ready held 1.
REQ-012 redirect SHALL: empty FIFO, cancel inflight response, set fetch_pc = {redirect_pc[31:2],2'b00}, clear halted; takes priority over push, pop and issue that cycle; first new fetch issued next cycle.
REQ-013 SHALL push returned EOF_WORD as a normal entry, set halted from next cycle, and discard any response issued after it.
REQ-014 SHALL set halted, without issuing, when fetch_pc >> 2 >= IMEM_WORDS.
REQ-015 Full: count == DEPTH blocks issue; no entry ever overwritten. Empty: id_valid=0, head outputs hold last value.
REQ-016 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-017 While rst=1: fetch_pc=0, count=0, pointers=0, inflight=0, halted=0, imem_rd_en=0, id_valid=0, id_instr=0, id_pc=0, counters=0.
REQ-018 rst asserted mid-operation SHALL discard queue and any pending response in that cycle; first fetch (index 0) in first cycle with rst=0.

Configuration
REQ-019 Macro FETCH_PERF_EN: defined -> fetch_count increments per pop, bubble_count per cycle with id_ready && !id_valid && !rst, both wrap at 2^32; undefined -> both ports constant 0, no counter flops.

Verification
REQ-020 Reset release, imem words 0..3 = 0x00A00093,0x00100113,0x002081B3,EOF, id_ready=1 -> rd_en at index 0 in cycle 1; id_valid cycle 3 with pc 0x0; pcs 0x0,0x4,0x8,0xC consecutive; halted=1 after EOF; fetch_count=4 (FETCH_PERF_EN).
REQ-021 id_ready=0 for 10 cycles, DEPTH=4 -> count reaches 4, imem_rd_en low while full, no lost or duplicate pc on release.
REQ-022 redirect=1 with redirect_pc=0x20 while queue holds 3 entries and one inflight -> id_valid=0 that cycle, next delivered id_pc=0x20, none of pre-redirect entries delivered.
REQ-023 redirect and id_ready both 1 with queue non-empty -> no pop counted, fetch_count unchanged.
REQ-024 Straight-line code with no EOF, IMEM_WORDS=56 -> last issued index 55, halted=1, 56 instructions delivered.
REQ-025 rst pulsed 1 cycle with 2 entries queued -> id_valid=0 next cycle, fetch restarts at index 0, counters read 0.
